// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill: fetches a 16-byte line as four 32-bit beats and
// returns it with a one-cycle ready pulse; newer requests kill in-flight refills.
module icache_refill_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Icache_valid_req_i,
  input  logic [ADDR_W-1:0] Icache_addr_i,
  output logic              mem_ready_o,
  output logic [127:0]      mem_data_o,
  output logic              refill_busy_o,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i
);

  localparam int LW = ADDR_W - 4;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   line_q, line_d;
  logic [LW-1:0]   pend_addr_q, pend_addr_d;
  logic [LW-1:0]   req_line;
  logic [1:0]      beat_q, beat_d;
  logic            pend_v_q, pend_v_d;
  logic            stale_q, stale_d;
  logic            beat_wr;
  logic [127:0]    buf_q;
  logic [127:0]    data_q;
  logic            unused_addr_lsb;

  assign req_line        = Icache_addr_i[ADDR_W-1:4];
  assign unused_addr_lsb = ^Icache_addr_i[3:0];

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    pend_addr_d = pend_addr_q;
    beat_d      = beat_q;
    pend_v_d    = pend_v_q;
    stale_d     = stale_q;
    beat_wr     = 1'b0;
    case (state_q)
      IDLE: begin
        // A fresh request outranks an older pending one: the latest request wins.
        if (Icache_valid_req_i) begin
          line_d   = req_line;
          beat_d   = 2'd0;
          stale_d  = 1'b0;
          pend_v_d = 1'b0;
          state_d  = REQ;
        end else if (pend_v_q) begin
          line_d   = pend_addr_q;
          beat_d   = 2'd0;
          stale_d  = 1'b0;
          pend_v_d = 1'b0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (Icache_valid_req_i) begin
          pend_v_d    = 1'b1;
          pend_addr_d = req_line;
          stale_d     = 1'b1;
        end
        if (bus_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (Icache_valid_req_i) begin
          pend_v_d    = 1'b1;
          pend_addr_d = req_line;
          stale_d     = 1'b1;
        end
        if (bus_rvalid_i) begin
          beat_wr = 1'b1;
          // A request in this very cycle also stales the refill and is taken directly.
          if (stale_q || Icache_valid_req_i) begin
            line_d   = Icache_valid_req_i ? req_line : pend_addr_q;
            beat_d   = 2'd0;
            pend_v_d = 1'b0;
            stale_d  = 1'b0;
            state_d  = REQ;
          end else if (beat_q == 2'd3) begin
            state_d = DONE;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = REQ;
          end
        end
      end
      DONE: begin
        if (Icache_valid_req_i) begin
          pend_v_d    = 1'b1;
          pend_addr_d = req_line;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      line_q      <= '0;
      pend_addr_q <= '0;
      beat_q      <= 2'd0;
      pend_v_q    <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      pend_addr_q <= pend_addr_d;
      beat_q      <= beat_d;
      pend_v_q    <= pend_v_d;
      stale_q     <= stale_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      logic [31:0] word_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          word_q <= '0;
        end else if (beat_wr && (beat_q == 2'(gi))) begin
          word_q <= bus_rdata_i;
        end
      end
      assign buf_q[32*gi +: 32] = word_q;
    end
  endgenerate

  // The assembly buffer keeps changing during dropped refills, so the
  // delivered line is held separately.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (state_q == DONE) begin
      data_q <= buf_q;
    end
  end

  assign mem_ready_o   = (state_q == DONE);
  assign mem_data_o    = (state_q == DONE) ? buf_q : data_q;
  assign refill_busy_o = (state_q != IDLE) || pend_v_q;
  assign bus_req_o     = (state_q == REQ);
  assign bus_addr_o    = (state_q == REQ) ? {line_q, beat_q, 2'b00} : '0;

endmodule
